pmcc_code_mem: RTL
==================

Name: pmcc_code_mem

Overview:
- Byte-addressed program memory that feeds the PMC coprocessor its instruction stream.
- Each cycle it takes the coprocessor's next fetch address and returns, one clock later, the 32-bit window starting at that byte. The core's 1-4 byte variable-length instructions can therefore start at any byte offset.
- Storage is split into two word-wide banks (even/odd word index), so an unaligned window is read in one cycle.
- A host-side bus port lets the SoC CPU load and read back the program while the coprocessor is held off.

Parameters:
- DEPTH_WORDS, 256, total 32-bit words; power of 2, >=4; each bank holds DEPTH_WORDS/2.
- AW, 10, byte-address width of the fetch port; AW = log2(DEPTH_WORDS)+2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- fetch_en  input  1  coprocessor running (driven by pmcc_rst_n); 1 = fetch owns both banks
- pc_if  input  AW  byte address of the next instruction
- instr  output  32  window at registered pc; byte at pc in instr[7:0]
- bus_req  input  1  host access request
- bus_we  input  1  1 = write
- bus_addr  input  AW-2  host word address
- bus_be  input  4  byte enables for writes
- bus_wdata  input  32  write data
- bus_gnt  output  1  request accepted this cycle
- bus_rvalid  output  1  read data valid (one cycle after granted read)
- bus_rdata  output  32  read data
- parity_err  output  1  sticky parity error (only with optional feature; tied 0 otherwise)

Behaviour:
- Reset: instr=0, bus_rvalid=0, bus_rdata=0, parity_err=0, internal offset/odd registers=0. Memory contents are not reset.
- Fetch address split:
  - w = pc_if[AW-1:2], b = pc_if[1:0]; w1 = (w+1) mod DEPTH_WORDS.
  - Wrap: last word pairs with word 0.
  - Even bank index = (w even ? w : w1)>>1; odd bank index = (w odd ? w : w1)>>1.
- Fetch timing:
  - Banks read synchronously when fetch_en=1.
  - b and w[0] are registered alongside the read.
  - Next cycle: lo = word w, hi = word w1 (selected by registered w[0]); instr = ({hi,lo} >> 8*b_q)[31:0].
  - Latency exactly 1 cycle, so instr always corresponds to the coprocessor's pc_id.
  - When fetch_en=0, instr is forced to 0 on the next edge and stays 0. The coprocessor then decodes a known value.
- Host arbitration:
  - bus_gnt = bus_req & ~fetch_en, combinational.
  - Fetch has absolute priority; a host request while fetch_en=1 stalls (gnt=0) and no access occurs.
- Host write: on a granted write, the bytes with bus_be[i]=1 are written to word bus_addr at that edge; other bytes are unchanged. be=0 is a legal no-op.
- Host read:
  - A granted read registers the word; bus_rvalid=1 with bus_rdata on the next cycle, for exactly one cycle.
  - bus_rdata holds its value afterwards.
  - Back-to-back granted reads give consecutive rvalid pulses.
- fetch_en rising while a read is in flight: the pending rvalid still completes on the following cycle.
- fetch_en rising: the first valid instr appears one cycle after the first fetch edge.
- Async reset mid-operation: outputs go to reset values immediately. A write in progress at the reset edge is not guaranteed.

Optional Feature:
- Macro: PMCC_CODE_MEM_PARITY_EN.
- With the macro defined:
  - Each stored byte carries an even-parity bit, written with the byte.
  - On every fetch, each of the 8 bytes in {hi,lo} is checked; a mismatch sets parity_err, which stays 1 until rst_n.
  - Host reads are checked too; a mismatch sets parity_err in the same cycle as rvalid.
  - instr is still delivered unmodified.
- Without the macro: no parity storage, parity_err tied 0.

Test Plan:
- Load words 0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (fetch_en=0), then fetch_en=1:
  - pc_if=0 -> instr=0x03020100 next cycle.
  - pc_if=5 -> 0x08070605.
  - pc_if=7 -> 0x0A090807.
- Wrap: word 255=0xDDCCBBAA, word 0=0x44332211:
  - pc_if=0x3FE -> instr=0x2211DDCC.
  - pc_if=0x3FF -> 0x332211DD.
- Host arbitration:
  - fetch_en=1, bus_req write 0xDEADBEEF to word 4 -> bus_gnt=0, word 4 unchanged on readback.
  - Drop fetch_en -> gnt=1 the same cycle, write lands.
- Byte enables: word 2=0x11223344, write be=4'b0101 data 0xAABBCCDD -> readback 0x11BB33DD, rvalid exactly one cycle after gnt.
- Reset/disable:
  - Assert rst_n=0 mid-fetch -> instr=0 immediately; memory contents retained on readback.
  - fetch_en=0 -> instr=0 after one edge.
- PARITY_EN: force-flip one stored bit of word 1, fetch pc_if=4 -> parity_err=1 next cycle and stays 1 until rst_n; without the macro, parity_err=0 throughout.

Source files
------------

// File: rtl/pmcc_code_mem.sv
// pmcc_code_mem
//   Byte-addressed program memory for the PMC coprocessor. Each cycle the
//   fetch port takes a byte address and, one clock later, presents the 32-bit
//   window starting at that byte (byte at pc in instr[7:0]). Words live in two
//   banks (even / odd word index) so that any unaligned window needs exactly
//   one read from each bank. A host bus port loads and reads back the program
//   while the coprocessor is held off (fetch_en=0); fetch always wins.
//
//   Optional feature: define PMCC_CODE_MEM_PARITY_EN to store an even-parity
//   bit per byte and raise a sticky parity_err on fetch or host-read mismatch.
//   Without it parity_err is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_en            1 = coprocessor running, fetch owns both banks
//   pc_if [AW-1:0]      byte address of the next instruction
//   instr [31:0]        window at the registered pc (0 while not fetching)
//   bus_req/bus_we      host request / write select
//   bus_addr [AW-3:0]   host word address
//   bus_be [3:0]        write byte enables
//   bus_wdata [31:0]    write data
//   bus_gnt             request accepted this cycle (combinational)
//   bus_rvalid          one-cycle pulse, read data valid
//   bus_rdata [31:0]    read data, held after the pulse
//   parity_err          sticky parity error
module pmcc_code_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc_if,
    output logic [31:0]   instr,
    input  logic          bus_req,
    input  logic          bus_we,
    input  logic [AW-3:0] bus_addr,
    input  logic [3:0]    bus_be,
    input  logic [31:0]   bus_wdata,
    output logic          bus_gnt,
    output logic          bus_rvalid,
    output logic [31:0]   bus_rdata,
    output logic          parity_err
);

    localparam int WW         = AW - 2;        // word address width
    localparam int IW         = AW - 3;        // per-bank index width
    localparam int BANK_DEPTH = DEPTH_WORDS / 2;

    // Fetch address split; w1 wraps naturally at WW bits so the last word
    // pairs with word 0.
    logic [WW-1:0] fetch_w;
    logic [WW-1:0] fetch_w1;
    logic [1:0]    fetch_b;
    logic [IW-1:0] even_idx;
    logic [IW-1:0] odd_idx;

    assign fetch_w  = pc_if[AW-1:2];
    assign fetch_b  = pc_if[1:0];
    assign fetch_w1 = fetch_w + 1'b1;
    assign even_idx = fetch_w[0] ? fetch_w1[WW-1:1] : fetch_w[WW-1:1];
    assign odd_idx  = fetch_w[0] ? fetch_w[WW-1:1]  : fetch_w1[WW-1:1];

    // Host side
    logic          host_rd;
    logic          host_wr;
    logic          host_bank;
    logic [IW-1:0] host_idx;

    assign bus_gnt   = bus_req & ~fetch_en;
    assign host_rd   = bus_gnt & ~bus_we;
    assign host_wr   = bus_gnt & bus_we;
    assign host_bank = bus_addr[0];
    assign host_idx  = bus_addr[WW-1:1];

    logic [31:0] bank_rdata [2];
`ifdef PMCC_CODE_MEM_PARITY_EN
    logic [3:0]  bank_prdata [2];
`endif

    // Two single-port banks: address comes from fetch when running, else host.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [31:0]   mem [BANK_DEPTH];
        logic [31:0]   rd_reg;
        logic [IW-1:0] idx;
        logic          sel;
        logic          en;
        logic          we;

        assign idx = fetch_en ? ((gi == 0) ? even_idx : odd_idx) : host_idx;
        assign sel = (host_bank == 1'(gi));
        assign we  = host_wr & sel;
        assign en  = fetch_en | (host_rd & sel);

        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_be[i]) begin
                        mem[idx][8*i +: 8] <= bus_wdata[8*i +: 8];
                    end
                end
            end
            if (en) begin
                rd_reg <= mem[idx];
            end
        end

        assign bank_rdata[gi] = rd_reg;

`ifdef PMCC_CODE_MEM_PARITY_EN
        logic [3:0] pmem [BANK_DEPTH];
        logic [3:0] prd_reg;

        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_be[i]) begin
                        pmem[idx][i] <= ^bus_wdata[8*i +: 8];
                    end
                end
            end
            if (en) begin
                prd_reg <= pmem[idx];
            end
        end

        assign bank_prdata[gi] = prd_reg;
`endif
    end

    // Control registers
    logic        fetch_valid_reg;   // instr is meaningful this cycle
    logic [1:0]  b_reg;             // byte offset of registered pc
    logic        odd_reg;           // registered w[0]: which bank holds word w
    logic        rvalid_reg;
    logic        rsel_reg;          // bank of the in-flight host read
    logic [31:0] rdata_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_reg <= 1'b0;
            b_reg           <= 2'd0;
            odd_reg         <= 1'b0;
            rvalid_reg      <= 1'b0;
            rsel_reg        <= 1'b0;
            rdata_hold_reg  <= 32'd0;
        end else begin
            fetch_valid_reg <= fetch_en;
            if (fetch_en) begin
                b_reg   <= fetch_b;
                odd_reg <= fetch_w[0];
            end
            rvalid_reg <= host_rd;
            if (host_rd) begin
                rsel_reg <= host_bank;
            end
            // Keep the read word after the pulse: the bank register is
            // overwritten by later fetches.
            if (rvalid_reg) begin
                rdata_hold_reg <= bank_rdata[rsel_reg];
            end
        end
    end

    // Window assembly
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [31:0] window;

    assign lo_word = odd_reg ? bank_rdata[1] : bank_rdata[0];
    assign hi_word = odd_reg ? bank_rdata[0] : bank_rdata[1];
    assign window  = 32'({hi_word, lo_word} >> {b_reg, 3'b000});
    assign instr   = fetch_valid_reg ? window : 32'd0;

    assign bus_rvalid = rvalid_reg;
    assign bus_rdata  = rvalid_reg ? bank_rdata[rsel_reg] : rdata_hold_reg;

`ifdef PMCC_CODE_MEM_PARITY_EN
    function automatic logic par_bad(input logic [31:0] d, input logic [3:0] p);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((^d[8*i +: 8]) != p[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    logic perr_now;
    logic perr_reg;

    // Detected in the same cycle the data is presented; the register keeps
    // it sticky afterwards.
    assign perr_now = (fetch_valid_reg & (par_bad(bank_rdata[0], bank_prdata[0]) |
                                          par_bad(bank_rdata[1], bank_prdata[1]))) |
                      (rvalid_reg & par_bad(bank_rdata[rsel_reg], bank_prdata[rsel_reg]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_reg <= 1'b0;
        end else if (perr_now) begin
            perr_reg <= 1'b1;
        end
    end

    assign parity_err = perr_reg | perr_now;
`else
    assign parity_err = 1'b0;
`endif

endmodule
